// File: rtl/vga_pkg.sv
// Shared types and frame geometry for the frame-buffer arbiter.
// No logic; constants and enums only.
// No flow control; consumers import the types.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int FB_PIXELS  = H_ACTIVE * V_ACTIVE;
    localparam int FB_P_SIZE  = $clog2(FB_PIXELS);

    // Who issued the read that returns data next cycle.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        DISP = 2'd1,
        HOST = 2'd2
    } owner_e;

    // Screen-fill sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous command FIFO for host accesses, head visible combinationally.
// Latency: a pushed entry is at the head the cycle after the push when empty.
// Backpressure: push ignored while full, pop ignored while empty.
module vga_cmd_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q, wr_d;
    logic [PW:0]  rd_q, rd_d;
    logic         do_push, do_pop;

    assign full_o     = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign empty_o    = (wr_q == rd_q);
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;
    assign head_dat_o = mem_q[rd_q[PW-1:0]];

    // Pointer advance; the extra MSB separates full from empty.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: empty flag guards stale entries.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display > fill engine > host FIFO.
// Latency: read data returns one cycle after the grant (RAM latency only).
// Backpressure: host_ready drops when the FIFO is full or a fill is active.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int AW         = 19,
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int PIXELS     = FB_PIXELS
) (
    input  logic          pixel_clk,
    input  logic          reset_n,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_data,
    output logic          disp_valid,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_data,
    output logic          fill_busy,
    output logic          fill_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int            CMD_W     = 1 + AW + DW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PIXELS - 1);

    fill_state_e      state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    colour_q, colour_d;
    logic [DW-1:0]    disp_hold_q, host_hold_q;

    logic             fifo_full, fifo_empty, fifo_push;
    logic [CMD_W-1:0] fifo_head;
    logic             head_we;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_wdata;
    logic             grant_disp, grant_fill, grant_host;

    assign {head_we, head_addr, head_wdata} = fifo_head;

    // Ready depends only on registered state, never on this cycle's pop.
    assign host_ready = ~fifo_full & (state_q == IDLE);
    assign fifo_push  = host_valid & host_ready;

    vga_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i      (pixel_clk),
        .rst_n_i    (reset_n),
        .push_i     (fifo_push),
        .push_dat_i ({host_we, host_addr, host_wdata}),
        .pop_i      (grant_host),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Fixed-priority grant; host drains while idle and during the pre-fill drain.
    always_comb begin
        grant_disp = reset_n & disp_req;
        grant_fill = reset_n & ~disp_req & (state_q == FILL);
        grant_host = reset_n & ~disp_req & ~fifo_empty &
                     ((state_q == IDLE) | (state_q == DRAIN));
    end

    // RAM port driven straight from the grant so accesses cost no extra cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_disp) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (grant_fill) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = colour_q;
        end else if (grant_host) begin
            mem_en    = 1'b1;
            mem_we    = head_we;
            mem_addr  = head_addr;
            mem_wdata = head_wdata;
        end
    end

    // Tag the read issued this cycle so its data is routed next cycle.
    always_comb begin
        owner_d = NONE;
        if (grant_disp)                owner_d = DISP;
        else if (grant_host & ~head_we) owner_d = HOST;
    end

    // Owner tag plus last-value holders for the two read data outputs.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q     <= NONE;
            disp_hold_q <= '0;
            host_hold_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (owner_q == DISP) disp_hold_q <= mem_rdata;
            if (owner_q == HOST) host_hold_q <= mem_rdata;
        end
    end

    assign disp_valid  = (owner_q == DISP);
    assign host_rvalid = (owner_q == HOST);
    assign disp_data   = disp_valid  ? mem_rdata : disp_hold_q;
    assign host_rdata  = host_rvalid ? mem_rdata : host_hold_q;

    // Fill sequencer next state: drain host queue, write every pixel, pulse done.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        colour_d = colour_q;
        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d  = DRAIN;
                    colour_d = fill_data;
                    cnt_d    = '0;
                end
            end
            DRAIN: begin
                if (fifo_empty) state_d = FILL;
            end
            FILL: begin
                if (grant_fill) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fill sequencer registers; reset abandons any partial fill.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            colour_q <= colour_d;
        end
    end

    assign fill_busy = (state_q != IDLE);
    assign fill_done = (state_q == DONE);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised bench with a behavioural memory model and scoreboard queues.
// Expected RAM operations, host read data and display data are queued at issue time.
// A negedge monitor pops and compares whenever the DUT presents a result.
module tb_vga_fb_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 12;
    localparam int FD  = 4;
    localparam int PIX = 16;

    typedef struct packed {
        logic          fill;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } op_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          host_valid;
    logic          host_ready;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          fill_start;
    logic [DW-1:0] fill_data;
    logic          fill_busy;
    logic          fill_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    op_t           exp_ops[$];
    logic [DW-1:0] exp_host[$];
    logic [DW-1:0] exp_disp[$];
    logic [DW-1:0] ram    [256];
    logic [DW-1:0] shadow [256];

    bit  fill_active    = 0;
    bit  prev_disp      = 0;
    bit  saw7           = 0;
    int  fills_expected = 0;
    int  fills_seen     = 0;
    int  accepted       = 0;
    op_t o;
    logic [DW-1:0] e;

    vga_fb_arbiter #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(FD), .PIXELS(PIX)
    ) dut (
        .pixel_clk  (clk),
        .reset_n    (rst_n),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_rvalid(host_rvalid),
        .fill_start (fill_start),
        .fill_data  (fill_data),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, wanted 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor / scoreboard / reference model, all at the inactive edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check(!mem_en && !mem_we, "rst_mem", {mem_en, mem_we}, 0);
            check(!disp_valid && !host_rvalid, "rst_valid", {disp_valid, host_rvalid}, 0);
            check(!fill_busy && !fill_done, "rst_fill", {fill_busy, fill_done}, 0);
            check(disp_data == '0 && host_rdata == '0, "rst_data", {disp_data, host_rdata}, 0);
            exp_ops.delete();
            exp_host.delete();
            exp_disp.delete();
            if (fill_active) fills_expected--;
            fill_active = 0;
            prev_disp   = 0;
        end else begin
            check(disp_valid == prev_disp, "disp_valid_lat", disp_valid, prev_disp);
            if (disp_valid) begin
                if (exp_disp.size() == 0) check(0, "disp_unexpected", disp_data, 0);
                else begin
                    e = exp_disp.pop_front();
                    check(disp_data == e, "disp_data", disp_data, e);
                end
            end
            if (host_rvalid) begin
                if (exp_host.size() == 0) check(0, "host_unexpected", host_rdata, 0);
                else begin
                    e = exp_host.pop_front();
                    check(host_rdata == e, "host_rdata", host_rdata, e);
                end
            end
            check(fill_busy == fill_active, "fill_busy", fill_busy, fill_active);
            if (fill_active) check(!host_ready, "host_ready_fill", host_ready, 0);
            if (disp_req) begin
                check(mem_en && !mem_we && mem_addr == disp_addr, "disp_grant",
                      {mem_en, mem_we, mem_addr}, {2'b10, disp_addr});
                exp_disp.push_back(ram[disp_addr]);
            end else if (mem_en) begin
                if (exp_ops.size() == 0) begin
                    check(0, "mem_unexpected", {mem_we, mem_addr, mem_wdata}, 0);
                end else begin
                    o = exp_ops.pop_front();
                    check(mem_we == o.we && mem_addr == o.addr && (!o.we || mem_wdata == o.dat),
                          "mem_op", {mem_we, mem_addr, mem_wdata}, {o.we, o.addr, o.dat});
                    if (o.fill && o.addr == 7) saw7 = 1;
                end
            end
            if (host_valid && host_ready) begin
                accepted++;
                if (host_we) begin
                    shadow[host_addr] = host_wdata;
                    exp_ops.push_back('{fill: 1'b0, we: 1'b1, addr: host_addr, dat: host_wdata});
                end else begin
                    exp_ops.push_back('{fill: 1'b0, we: 1'b0, addr: host_addr, dat: '0});
                    exp_host.push_back(shadow[host_addr]);
                end
            end
            if (fill_start && !fill_active) begin
                fill_active = 1;
                fills_expected++;
                for (int i = 0; i < PIX; i++) begin
                    shadow[i] = fill_data;
                    exp_ops.push_back('{fill: 1'b1, we: 1'b1, addr: AW'(i), dat: fill_data});
                end
            end
            if (fill_done) begin
                fills_seen++;
                check(fill_active && exp_ops.size() == 0, "fill_done", exp_ops.size(), 0);
                fill_active = 0;
            end
            prev_disp = disp_req;
        end
    end

    task automatic host_cmd(input logic we, input int a, input int d);
        bit ok = 0;
        @(posedge clk); #1;
        host_valid = 1; host_we = we; host_addr = AW'(a); host_wdata = DW'(d);
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (host_ready) ok = 1;
        end
        if (!ok) check(0, "host_cmd_timeout", 0, 1);
        @(posedge clk); #1;
        host_valid = 0;
    endtask

    task automatic wait_quiet();
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk);
            if (exp_ops.size() == 0 && exp_host.size() == 0 && exp_disp.size() == 0 && !fill_active)
                ok = 1;
        end
        if (!ok) check(0, "quiet_timeout", exp_ops.size(), 0);
    endtask

    task automatic run_fill(input int colour, input int second_at);
        int  base = fills_seen;
        bit  done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk); #1;
            disp_req   = c[0];
            disp_addr  = AW'($urandom);
            fill_start = (c == 0) || (c == second_at);
            fill_data  = (c == 0) ? DW'(colour) : DW'($urandom);
            if (fills_seen != base) done = 1;
        end
        fill_start = 0;
        disp_req   = 0;
        check(done, "fill_done_timeout", done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int burst = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = DW'(i * 37 + 5);
            shadow[i] = DW'(i * 37 + 5);
        end
        rst_n = 0; disp_req = 0; disp_addr = '0; host_valid = 0; host_we = 0;
        host_addr = '0; host_wdata = '0; fill_start = 0; fill_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check(host_ready, "ready_after_reset", host_ready, 1);

        // Display holds the RAM; a queued host write waits then issues next cycle.
        @(posedge clk); #1 disp_req = 1;
        host_cmd(1, 40, 12'h5A5);
        repeat (640) begin
            @(posedge clk); #1 disp_addr = disp_addr + 1'b1;
        end
        @(posedge clk); #1 disp_req = 0;
        @(negedge clk);
        check(mem_en && mem_we && mem_addr == 8'd40 && mem_wdata == 12'h5A5, "host_after_disp",
              {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 8'd40, 12'h5A5});
        wait_quiet();

        // Host order: read, write, read of the same address.
        host_cmd(0, 5, 0);
        host_cmd(1, 5, 12'hABC);
        host_cmd(0, 5, 0);
        wait_quiet();

        // FIFO fills while the display blocks it.
        @(posedge clk); #1 disp_req = 1;
        base = accepted;
        repeat (8) begin
            @(posedge clk); #1;
            host_valid = 1; host_we = 0; host_addr = AW'($urandom_range(0, 31));
        end
        @(negedge clk);
        check(!host_ready, "ready_when_full", host_ready, 0);
        check(accepted - base == FD, "fifo_capacity", accepted - base, FD);
        @(posedge clk); #1 host_valid = 0; disp_req = 0;
        wait_quiet();

        // Fill after two queued host writes, with a second start mid-fill.
        @(posedge clk); #1 disp_req = 1;
        host_cmd(1, 3, 12'h111);
        host_cmd(1, 9, 12'h222);
        run_fill(12'hF00, 12);
        wait_quiet();

        // Random mixed traffic.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (burst == 0) begin
                disp_req = ~disp_req;
                burst    = $urandom_range(1, 40);
            end
            burst--;
            disp_addr  = AW'($urandom);
            host_valid = $urandom_range(0, 1);
            host_we    = $urandom_range(0, 1);
            host_addr  = AW'($urandom_range(0, 31));
            host_wdata = DW'($urandom);
            fill_start = ($urandom_range(0, 299) == 0);
            fill_data  = DW'($urandom);
        end
        @(posedge clk); #1;
        disp_req = 0; host_valid = 0; fill_start = 0;
        wait_quiet();

        // Abort a fill at address 7 with reset, then refill from zero.
        saw7 = 0;
        base = fills_seen;
        @(posedge clk); #1 fill_start = 1; fill_data = 12'h123;
        @(posedge clk); #1 fill_start = 0;
        for (int i = 0; i < 200 && !saw7; i++) @(posedge clk);
        check(saw7, "abort_reach_addr7", saw7, 1);
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check(host_ready, "ready_after_abort", host_ready, 1);
        check(fills_seen == base, "no_done_on_abort", fills_seen, base);
        run_fill(12'h456, -1);
        wait_quiet();

        // Read back the low addresses.
        for (int a = 0; a < 32; a++) host_cmd(0, a, 0);
        wait_quiet();

        check(fills_seen == fills_expected, "fill_count", fills_seen, fills_expected);
        check(exp_ops.size() == 0 && exp_host.size() == 0, "queues_empty",
              exp_ops.size() + exp_host.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
